luma_auto_contrast_sel: RTL and testbench
=========================================

# luma_auto_contrast_sel

Per-frame luminance statistics block that watches the same RGB565 camera stream fed to the contrast-enhancement stage and produces that stage's 3-bit curve select automatically, replacing the push-button cycling. It computes an approximate Y per valid pixel, accumulates over the frame, divides sum by pixel count after frame end with a sequential divider, and maps the mean to a curve index with multi-frame hysteresis. The block is observe-only: it never modifies or delays the video stream.

## Interface
- SUM_W, 28: accumulator and divider width; supports 2^CNT_W pixels of value 255
- CNT_W, 20: pixel-counter width
- HOLD_FRAMES, 2: consecutive frames a new bucket must persist before curve_sel changes (1..15)
- clk  in  1  pixel clock
- rst  in  1  reset, synchronous, active-high
- cam_vs  in  1  frame valid, high for the duration of a frame
- cam_de  in  1  line data enable
- cam_data  in  16  RGB565 pixel
- data_en_i  in  1  pixel qualifier; a pixel counts only when cam_de && data_en_i
- curve_sel  out  3  curve index 0..6 for the contrast stage (0 = bypass, 6 = strongest)
- mean_y  out  8  mean luminance of the last completed non-empty frame
- stat_valid  out  1  one-cycle pulse when mean_y is updated
- busy  out  1  high while FSM is not IDLE
- frame_drop  out  1  one-cycle pulse when a frame end is ignored because busy

## Operation
- Channel expansion: r={d[15:11],3'b0}, g={d[10:5],2'b0}, b={d[4:0],3'b0}.
- Luma: Y=(77r+150g+29b)>>8, 16-bit products, 2 register stages; qualifier pipelined alongside.
- Accumulator: sum+=Y, cnt+=1 per qualified pipelined pixel. If cnt reaches 2^CNT_W-1, further pixels of that frame are ignored (sum and cnt freeze together).
- Frame end F: first edge at which cam_vs is sampled 0 with previous sample 1.
- FSM: IDLE -> FLUSH (2 cycles, lets the luma pipeline drain) -> latch sum/cnt into divider, clear accumulators -> DIV (SUM_W cycles, restoring division, one quotient bit per cycle) -> UPDATE (1 cycle) -> IDLE.
- Latched cnt=0: skip DIV and UPDATE, return to IDLE; no stat_valid, mean_y/curve_sel/hold counter unchanged.
- UPDATE: mean_y=min(quotient,255); bucket=min(7-(mean_y>>5),6) (0-63->6, 64-95->5, 96-127->4, 128-159->3, 160-191->2, 192-223->1, 224-255->0).
- Hysteresis: bucket==curve_sel -> hold counter cleared. bucket==pending -> counter+1, else pending=bucket, counter=1. When counter reaches HOLD_FRAMES, curve_sel=pending, counter cleared.
- Accumulation of the next frame runs concurrently with DIV; frame end while busy: frame_drop pulse, that frame's accumulators cleared, no statistics.

## Timing
- Reset values: curve_sel=0, mean_y=0, stat_valid=0, busy=0, frame_drop=0; accumulators, divider, hold counter, pending cleared; FSM IDLE; vs edge history cleared (cam_vs high at reset release is not a frame end until it falls).
- Pixel sampled at edge N is in the accumulator after edge N+3.
- Accumulators latched at edge F+2; stat_valid, mean_y, curve_sel registered at edge F+SUM_W+3 (stat_valid high exactly one cycle).
- busy high from edge F through edge F+SUM_W+3; low otherwise.
- rst mid-DIV: abort immediately, all state to reset values, no stat_valid.
- Simultaneous cam_vs rise and UPDATE: both proceed independently.

## Test plan
- Uniform frame 0x8410 (Y=128), 64x4 pixels -> stat_valid at F+SUM_W+3, mean_y=128, bucket 3; curve_sel=3 after second such frame (HOLD_FRAMES=2).
- Frames of 0xFFFF (Y=250) x2 then 0x0000 x1 -> mean_y 250,250,0; curve_sel 0 after frame 2, stays 0 after frame 3.
- Half 0xFFFF, half 0x0000 per frame -> mean_y=125, bucket 4.
- Frame with data_en_i=0 on every pixel -> no stat_valid, outputs unchanged, busy for 3 cycles only.
- Pixels with cam_de=1, data_en_i=0 carrying 0xFFFF among 0x0000 valid pixels -> mean_y=0.
- Assert rst during DIV -> all outputs reset next edge, no stat_valid; next valid frame yields correct mean.

Source files
------------

// File: rtl/luma_auto_contrast_sel_if.sv
// rtl/luma_auto_contrast_sel_if.sv - camera tap and statistics bus for luma_auto_contrast_sel
// Purpose : groups the observed RGB565 camera stream and the statistics outputs.
// Signals : cam_vs, cam_de, cam_data[15:0], data_en_i  (camera side, into the block)
//           curve_sel[2:0], mean_y[7:0], stat_valid, busy, frame_drop (out of the block)
// Modports: master drives the camera side and observes results; slave is the block.
interface luma_auto_contrast_sel_if;
   logic        cam_vs;
   logic        cam_de;
   logic [15:0] cam_data;
   logic        data_en_i;
   logic [2:0]  curve_sel;
   logic [7:0]  mean_y;
   logic        stat_valid;
   logic        busy;
   logic        frame_drop;

   modport master (
      output cam_vs, cam_de, cam_data, data_en_i,
      input  curve_sel, mean_y, stat_valid, busy, frame_drop
   );

   modport slave (
      input  cam_vs, cam_de, cam_data, data_en_i,
      output curve_sel, mean_y, stat_valid, busy, frame_drop
   );
endinterface

// File: rtl/luma_auto_contrast_sel.sv
// rtl/luma_auto_contrast_sel.sv - per-frame mean luma to contrast curve select
// Purpose : observes an RGB565 stream, averages approximate Y over each frame and
//           picks a contrast curve (0 bypass .. 6 strongest) with frame hysteresis.
// Ports   : clk  - pixel clock
//           rst  - synchronous active-high reset
//           bus  - luma_auto_contrast_sel_if.slave (camera tap in, statistics out)
module luma_auto_contrast_sel #(
   parameter int SUM_W       = 28,
   parameter int CNT_W       = 20,
   parameter int HOLD_FRAMES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   luma_auto_contrast_sel_if.slave   bus
);
   localparam int RW  = SUM_W + 1;
   localparam int DCW = $clog2(SUM_W);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DIV, S_UPD} state_t;

   state_t state_q, state_d;

   // luma pipeline: input sample, products, Y
   logic [15:0] in_data_q;
   logic        in_qual_q, q1_q, q2_q;
   logic [15:0] pr_q, pg_q, pb_q;
   logic [7:0]  y_q;

   logic [SUM_W-1:0] sum_q, sum_nx;
   logic [CNT_W-1:0] cnt_q, cnt_nx;
   logic             acc_clr;

   logic             vs_q, fe;
   logic             flush_q, flush_d;
   logic [DCW-1:0]   div_cnt_q, div_cnt_d;
   logic [SUM_W-1:0] rem_q, rem_d, quo_q, quo_d;
   logic [CNT_W-1:0] dvs_q, dvs_d;
   logic [RW-1:0]    rem_sh;
   logic             rem_ge;
   logic [7:0]       mean_q, mean_d, mean_calc;
   logic [2:0]       curve_q, curve_d, pend_q, pend_d, bucket_calc;
   logic [3:0]       hold_q, hold_d, hold_inc;
   logic             stat_q, stat_d, busy_q, busy_d, drop_q, drop_d, latch;
   logic [1:0]       drop_sr_q, drop_sr_d;

   assign fe = vs_q & ~bus.cam_vs;

   // Accumulation freezes once the pixel count saturates so sum and count stay consistent.
   always_comb begin
      sum_nx = sum_q;
      cnt_nx = cnt_q;
      if (q2_q && (cnt_q != CNT_MAX)) begin
         sum_nx = sum_q + SUM_W'(y_q);
         cnt_nx = cnt_q + CNT_W'(1);
      end
   end

   // A dropped frame is cleared two cycles after its end, matching the normal flush,
   // so its in-flight pixels do not leak into the next frame.
   assign acc_clr = latch | drop_sr_q[1];

   assign rem_sh      = {rem_q, quo_q[SUM_W-1]};
   assign rem_ge      = rem_sh >= RW'(dvs_q);
   assign mean_calc   = (|quo_q[SUM_W-1:8]) ? 8'hFF : quo_q[7:0];
   assign bucket_calc = (mean_calc[7:5] == 3'd0) ? 3'd6 : 3'd7 - mean_calc[7:5];
   assign hold_inc    = (bucket_calc == pend_q) ? hold_q + 4'd1 : 4'd1;

   always_comb begin
      state_d   = state_q;
      flush_d   = flush_q;
      div_cnt_d = div_cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      mean_d    = mean_q;
      curve_d   = curve_q;
      pend_d    = pend_q;
      hold_d    = hold_q;
      stat_d    = 1'b0;
      latch     = 1'b0;
      drop_d    = fe & busy_q;
      case (state_q)
         S_IDLE: begin
            if (fe && !busy_q) begin
               state_d = S_FLUSH;
               flush_d = 1'b0;
            end
         end
         S_FLUSH: begin
            if (!flush_q) begin
               flush_d = 1'b1;
            end else begin
               // Latch includes the last pixel arriving at this same edge.
               latch = 1'b1;
               if (cnt_nx == '0) begin
                  state_d = S_IDLE;
               end else begin
                  state_d   = S_DIV;
                  rem_d     = '0;
                  quo_d     = sum_nx;
                  dvs_d     = cnt_nx;
                  div_cnt_d = '0;
               end
            end
         end
         S_DIV: begin
            // Restoring division: dividend shifts out of quo_q as quotient bits shift in.
            rem_d     = rem_ge ? rem_sh[SUM_W-1:0] - SUM_W'(dvs_q) : rem_sh[SUM_W-1:0];
            quo_d     = {quo_q[SUM_W-2:0], rem_ge};
            div_cnt_d = div_cnt_q + DCW'(1);
            if (div_cnt_q == DCW'(SUM_W - 1)) begin
               state_d = S_UPD;
            end
         end
         default: begin
            state_d = S_IDLE;
            stat_d  = 1'b1;
            mean_d  = mean_calc;
            if (bucket_calc == curve_q) begin
               hold_d = 4'd0;
            end else begin
               pend_d = bucket_calc;
               if (hold_inc == 4'(HOLD_FRAMES)) begin
                  curve_d = bucket_calc;
                  hold_d  = 4'd0;
               end else begin
                  hold_d = hold_inc;
               end
            end
         end
      endcase
      // busy stays up one cycle past IDLE entry so it covers the final registered edge.
      busy_d    = (state_d != S_IDLE) || (state_q != S_IDLE);
      drop_sr_d = {drop_sr_q[0], drop_d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         in_data_q <= '0;
         in_qual_q <= 1'b0;
         q1_q      <= 1'b0;
         q2_q      <= 1'b0;
         pr_q      <= '0;
         pg_q      <= '0;
         pb_q      <= '0;
         y_q       <= '0;
         sum_q     <= '0;
         cnt_q     <= '0;
         vs_q      <= 1'b0;
         flush_q   <= 1'b0;
         div_cnt_q <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         mean_q    <= '0;
         curve_q   <= '0;
         pend_q    <= '0;
         hold_q    <= '0;
         stat_q    <= 1'b0;
         busy_q    <= 1'b0;
         drop_q    <= 1'b0;
         drop_sr_q <= '0;
      end else begin
         state_q   <= state_d;
         in_data_q <= bus.cam_data;
         in_qual_q <= bus.cam_de & bus.data_en_i;
         pr_q      <= 16'({in_data_q[15:11], 3'b000}) * 16'd77;
         pg_q      <= 16'({in_data_q[10:5], 2'b00}) * 16'd150;
         pb_q      <= 16'({in_data_q[4:0], 3'b000}) * 16'd29;
         q1_q      <= in_qual_q;
         y_q       <= 8'((pr_q + pg_q + pb_q) >> 8);
         q2_q      <= q1_q;
         sum_q     <= acc_clr ? '0 : sum_nx;
         cnt_q     <= acc_clr ? '0 : cnt_nx;
         vs_q      <= bus.cam_vs;
         flush_q   <= flush_d;
         div_cnt_q <= div_cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         mean_q    <= mean_d;
         curve_q   <= curve_d;
         pend_q    <= pend_d;
         hold_q    <= hold_d;
         stat_q    <= stat_d;
         busy_q    <= busy_d;
         drop_q    <= drop_d;
         drop_sr_q <= drop_sr_d;
      end
   end

   assign bus.curve_sel  = curve_q;
   assign bus.mean_y     = mean_q;
   assign bus.stat_valid = stat_q;
   assign bus.busy       = busy_q;
   assign bus.frame_drop = drop_q;
endmodule

// File: tb/tb_luma_auto_contrast_sel.sv
// tb/tb_luma_auto_contrast_sel.sv - testbench for luma_auto_contrast_sel
module tb_luma_auto_contrast_sel;
   localparam int SUM_W = 28;
   localparam int CNT_W = 20;
   localparam int HOLD  = 2;
   localparam int K_CONST = 0, K_HALF = 1, K_NOEN = 2, K_MASK = 3;

   typedef struct {
      int          kind;
      logic [15:0] data;
      bit          has_stat;
      int          exp_mean;
      int          exp_curve;
   } vec_t;

   typedef struct {
      int mean;
      int curve;
      int at;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   drops = 0;
   exp_t exp_q[$];
   vec_t tbl[10];

   luma_auto_contrast_sel_if bus();

   luma_auto_contrast_sel #(
      .SUM_W(SUM_W), .CNT_W(CNT_W), .HOLD_FRAMES(HOLD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard side: every stat_valid pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (bus.frame_drop) drops++;
      if (bus.stat_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_stat_valid", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_mean_y", int'(bus.mean_y), e.mean);
            chk("sb_curve_sel", int'(bus.curve_sel), e.curve);
            chk("sb_stat_cycle", cyc, e.at);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   task automatic drive_frame(input int kind, input logic [15:0] data, input int lines,
                              input int ppl, output int f_cyc);
      @(negedge clk);
      bus.cam_vs = 1'b1;
      repeat (3) @(negedge clk);
      for (int l = 0; l < lines; l++) begin
         for (int p = 0; p < ppl; p++) begin
            bus.cam_de = 1'b1;
            case (kind)
               K_CONST: begin bus.cam_data = data; bus.data_en_i = 1'b1; end
               K_HALF:  begin bus.cam_data = (p < ppl / 2) ? 16'hFFFF : 16'h0000; bus.data_en_i = 1'b1; end
               K_NOEN:  begin bus.cam_data = 16'hFFFF; bus.data_en_i = 1'b0; end
               default: begin bus.cam_data = p[0] ? 16'h0000 : 16'hFFFF; bus.data_en_i = p[0]; end
            endcase
            @(negedge clk);
         end
         bus.cam_de    = 1'b0;
         bus.data_en_i = 1'b0;
         bus.cam_data  = 16'h0000;
         repeat (4) @(negedge clk);
      end
      bus.cam_vs = 1'b0;
      f_cyc = cyc + 1;
      @(negedge clk);
   endtask

   task automatic measure_busy(output int len);
      len = 0;
      for (int i = 0; i < 200; i++) begin
         if (!bus.busy) break;
         len++;
         @(negedge clk);
      end
   endtask

   initial begin
      int f, f2, blen;
      bus.cam_vs = 1'b0; bus.cam_de = 1'b0; bus.cam_data = 16'h0000; bus.data_en_i = 1'b0;

      tbl[0] = '{K_CONST, 16'h8410, 1'b1, 128, 0};
      tbl[1] = '{K_CONST, 16'h8410, 1'b1, 128, 3};
      tbl[2] = '{K_CONST, 16'hFFFF, 1'b1, 250, 3};
      tbl[3] = '{K_CONST, 16'hFFFF, 1'b1, 250, 0};
      tbl[4] = '{K_CONST, 16'h0000, 1'b1, 0,   0};
      tbl[5] = '{K_HALF,  16'h0000, 1'b1, 125, 0};
      tbl[6] = '{K_NOEN,  16'h0000, 1'b0, 125, 0};
      tbl[7] = '{K_HALF,  16'h0000, 1'b1, 125, 4};
      tbl[8] = '{K_MASK,  16'h0000, 1'b1, 0,   4};
      tbl[9] = '{K_CONST, 16'h4208, 1'b1, 64,  4};

      repeat (3) @(negedge clk);
      chk("reset_curve_sel", int'(bus.curve_sel), 0);
      chk("reset_mean_y", int'(bus.mean_y), 0);
      chk("reset_stat_valid", int'(bus.stat_valid), 0);
      chk("reset_busy", int'(bus.busy), 0);
      chk("reset_frame_drop", int'(bus.frame_drop), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         drive_frame(tbl[i].kind, tbl[i].data, 4, 64, f);
         if (tbl[i].has_stat) exp_q.push_back('{tbl[i].exp_mean, tbl[i].exp_curve, f + SUM_W + 3});
         measure_busy(blen);
         chk($sformatf("busy_len_vec%0d", i), blen, tbl[i].has_stat ? SUM_W + 4 : 3);
         chk($sformatf("mean_y_vec%0d", i), int'(bus.mean_y), tbl[i].exp_mean);
         chk($sformatf("curve_sel_vec%0d", i), int'(bus.curve_sel), tbl[i].exp_curve);
         repeat (3) @(negedge clk);
      end

      // Reset while the divider is running: no result, everything back to reset values.
      drive_frame(K_CONST, 16'hFFFF, 4, 64, f);
      repeat (10) @(negedge clk);
      chk("busy_mid_div", int'(bus.busy), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_div_curve_sel", int'(bus.curve_sel), 0);
      chk("rst_div_mean_y", int'(bus.mean_y), 0);
      chk("rst_div_stat_valid", int'(bus.stat_valid), 0);
      chk("rst_div_busy", int'(bus.busy), 0);
      chk("rst_div_frame_drop", int'(bus.frame_drop), 0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      drive_frame(K_CONST, 16'h8410, 4, 64, f);
      exp_q.push_back('{128, 0, f + SUM_W + 3});
      measure_busy(blen);
      chk("busy_len_after_rst", blen, SUM_W + 4);
      chk("mean_y_after_rst", int'(bus.mean_y), 128);
      repeat (3) @(negedge clk);

      // Short frame, then a frame ending while busy: dropped, and its pixels must not leak.
      drive_frame(K_CONST, 16'h8410, 1, 64, f);
      exp_q.push_back('{128, 3, f + SUM_W + 3});
      drive_frame(K_CONST, 16'hFFFF, 1, 8, f2);
      measure_busy(blen);
      chk("drop_returns_idle", int'(bus.busy), 0);
      chk("drop_count", drops, 1);
      chk("curve_sel_after_drop", int'(bus.curve_sel), 3);
      repeat (3) @(negedge clk);
      drive_frame(K_CONST, 16'h0000, 4, 64, f);
      exp_q.push_back('{0, 3, f + SUM_W + 3});
      measure_busy(blen);
      chk("mean_y_after_drop", int'(bus.mean_y), 0);
      chk("curve_sel_final", int'(bus.curve_sel), 3);

      repeat (10) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("drop_count_final", drops, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
